is_uart_calc_fsm: RTL and testbench
===================================

// Module: is_uart_calc_fsm
// PURPOSE
// Parametrised command/response engine between the UART RX/TX cores and the message ROM.
// Parses ASCII lines "<op><hex digits>\r\n" into an ACC_W-bit accumulator with selectable operation.
// Replies with a fixed-length ROM message plus the accumulator in ASCII hex, or with an error message.
// Hex<->ASCII conversion is internal.
// PARAMETERS
// DIGITS     8   max hex digits per operand; ACC_W = 4*DIGITS
// MEM_AW     8   message ROM address width
// MSG_LEN    16  bytes per ROM message, 1..2**MEM_AW
// OK_BASE    0   ROM base address of "OK" message
// ESYN_BASE  16  ROM base address of syntax-error message
// EPAR_BASE  32  ROM base address of parity-error message
// EFRM_BASE  48  ROM base address of framing-error message (also used for parity+framing)
// PORTS
// clk_i       in   1       clock
// rstn_i      in   1       asynchronous active-low reset
// rx_valid_i  in   1       1-cycle strobe, RX byte available
// rx_data_i   in   8       RX byte
// rx_perr_i   in   1       parity error flag, qualified by rx_valid_i
// rx_ferr_i   in   1       framing error flag, qualified by rx_valid_i
// tx_ready_i  in   1       TX core can accept a byte
// tx_valid_o  out  1       tx_data_o holds a byte to send
// tx_data_o   out  8       TX byte
// mem_addr_o  out  MEM_AW  ROM address
// mem_data_i  in   8       ROM data, valid 1 cycle after mem_addr_o
// acc_o       out  ACC_W   current accumulator
// busy_o      out  1       high in every state except IDLE
// err_o       out  1       1-cycle pulse when an error line is detected
// BEHAVIOUR
// - Reset: all outputs are 0, accumulator is 0, state is IDLE. Reset asserted mid-line or mid-reply aborts immediately.
// - TX handshake: a byte transfers when tx_valid_o & tx_ready_i.
//   - tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
// - rx_valid_i with rx_ferr_i has priority over rx_perr_i, which has priority over character checks.
//   - Framing error -> EFRM message; parity error -> EPAR message.
// - States:
//   - IDLE: the first byte is the op. '=' loads, '+' adds, '-' subtracts, '^' XORs. Op -> RDIG. Any other byte -> syntax error.
//   - RDIG: 0-9, A-F and a-f shift into the operand, MS digit first. The digit count is 1..DIGITS; fewer digits are zero-extended.
//     - '\r' after at least 1 digit -> RLF.
//     - '\r' with 0 digits, a (DIGITS+1)th digit, or any other byte -> syntax error.
//   - RLF: '\n' applies the op: acc = acc op operand, mod 2**ACC_W. Then -> TMSG with base OK_BASE. Any other byte -> syntax error.
//   - TMSG: sends ROM[base .. base+MSG_LEN-1] in order, prefetching 1 byte ahead.
//     - tx_valid_o rises no later than 3 cycles after the accepting rx_valid_i.
//     - Then -> TRES after OK, or -> TCR after an error.
//   - TRES: sends DIGITS uppercase ASCII hex chars of acc, MS first, so leading zeros are kept. Then -> TCR.
//   - TCR: sends 0x0D. TLF: sends 0x0A, then -> IDLE. If the line was aborted before its '\n', -> SKIP instead.
//   - SKIP: discards bytes until '\n', with or without errors, then -> IDLE. No reply.
// - Error: err_o pulses, acc is unchanged, the partial operand is discarded, and the reply is the message plus "\r\n".
// - rx_valid_i in TMSG/TRES/TCR/TLF: the byte is dropped silently. The state and the pending abort flag are unchanged.
// - The operand and digit counter clear on every entry to IDLE.
// TESTING
// DIGITS=4, MSG_LEN=4, ROM "OK  ","ESYN","EPAR","EFRM":
// "=1234\r\n" -> TX "OK  1234\r\n"; acc_o=16'h1234.
// Then "+ff\r\n" -> "OK  1333\r\n"; then "-2000\r\n" -> "OK  F333\r\n" (wrap).
// "+12345\r\n" -> "ESYN\r\n" sent right after the 5th digit, err_o 1 pulse, rest of line skipped, acc unchanged; next "^1\r\n" works.
// Byte '3' with rx_perr_i=1 mid-line -> "EPAR\r\n"; same with rx_ferr_i=1 as well -> "EFRM\r\n".
// "=A\r\n" with tx_ready_i low 50 cycles per byte -> tx_data_o stable while stalled; reply "OK  000A\r\n".
// rstn_i pulsed during TRES -> all outputs 0 at once; next "=1\r\n" -> "OK  0001\r\n".

Source files
------------

// File: rtl/is_uart_calc_fsm.sv
// Line-oriented calculator engine: parses "<op><hex>\r\n" from the UART RX core,
// updates an accumulator and streams a ROM message plus the result to the UART TX core.
module is_uart_calc_fsm #(
    parameter int DIGITS    = 8,
    parameter int MEM_AW    = 8,
    parameter int MSG_LEN   = 16,
    parameter int OK_BASE   = 0,
    parameter int ESYN_BASE = 16,
    parameter int EPAR_BASE = 32,
    parameter int EFRM_BASE = 48,
    localparam int ACC_W    = 4 * DIGITS
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_perr_i,
    input  logic              rx_ferr_i,
    input  logic              tx_ready_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    localparam int CNT_MAX = (DIGITS > MSG_LEN) ? DIGITS : MSG_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int NW      = $clog2(DIGITS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RDIG = 3'd1;
    localparam logic [2:0] S_RLF  = 3'd2;
    localparam logic [2:0] S_TMSG = 3'd3;
    localparam logic [2:0] S_TRES = 3'd4;
    localparam logic [2:0] S_TCR  = 3'd5;
    localparam logic [2:0] S_TLF  = 3'd6;
    localparam logic [2:0] S_SKIP = 3'd7;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam logic [MEM_AW-1:0] A_OK   = MEM_AW'(OK_BASE);
    localparam logic [MEM_AW-1:0] A_ESYN = MEM_AW'(ESYN_BASE);
    localparam logic [MEM_AW-1:0] A_EPAR = MEM_AW'(EPAR_BASE);
    localparam logic [MEM_AW-1:0] A_EFRM = MEM_AW'(EFRM_BASE);

    // TX handshake: a byte moves when tx_valid_o & tx_ready_i on a rising clk_i;
    // tx_data_o only reloads when the output slot is empty or being drained.

    logic [2:0]        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_opnd;
    logic [ACC_W-1:0]  r_shr;
    logic [NW-1:0]     r_ndig;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic              r_ok;
    logic              r_abort;
    logic              r_lf_sent;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_mem_vld;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_err;

    logic              w_is_dig;
    logic [3:0]        w_nib;
    logic              w_is_op;
    logic [1:0]        w_op;
    logic              w_slot;
    logic              w_err;
    logic [MEM_AW-1:0] w_err_base;
    logic [ACC_W-1:0]  w_acc_nx;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Letters A-F and a-f both carry 1..6 in the low nibble.
    always_comb begin
        w_is_dig = 1'b0;
        w_nib    = 4'h0;
        if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
            w_is_dig = 1'b1;
            w_nib    = rx_data_i[3:0];
        end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                     (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
            w_is_dig = 1'b1;
            w_nib    = rx_data_i[3:0] + 4'd9;
        end
    end

    always_comb begin
        w_is_op = 1'b1;
        w_op    = 2'd0;
        case (rx_data_i)
            8'h3D:   w_op = 2'd0;
            8'h2B:   w_op = 2'd1;
            8'h2D:   w_op = 2'd2;
            8'h5E:   w_op = 2'd3;
            default: w_is_op = 1'b0;
        endcase
    end

    always_comb begin
        w_acc_nx = r_opnd;
        case (r_op)
            2'd0:    w_acc_nx = r_opnd;
            2'd1:    w_acc_nx = r_acc + r_opnd;
            2'd2:    w_acc_nx = r_acc - r_opnd;
            default: w_acc_nx = r_acc ^ r_opnd;
        endcase
    end

    // Line errors only arise while parsing; framing beats parity beats syntax.
    always_comb begin
        w_err      = 1'b0;
        w_err_base = A_ESYN;
        if (rx_valid_i && (r_state == S_IDLE || r_state == S_RDIG || r_state == S_RLF)) begin
            if (rx_ferr_i) begin
                w_err      = 1'b1;
                w_err_base = A_EFRM;
            end else if (rx_perr_i) begin
                w_err      = 1'b1;
                w_err_base = A_EPAR;
            end else begin
                case (r_state)
                    S_IDLE: w_err = !w_is_op;
                    S_RDIG: begin
                        if (w_is_dig)
                            w_err = (r_ndig == NW'(DIGITS));
                        else if (rx_data_i == CH_CR)
                            w_err = (r_ndig == '0);
                        else
                            w_err = 1'b1;
                    end
                    default: w_err = (rx_data_i != CH_LF);
                endcase
            end
        end
    end

    assign w_slot = !r_tx_valid || tx_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_shr      <= '0;
            r_ndig     <= '0;
            r_cnt      <= '0;
            r_op       <= 2'd0;
            r_ok       <= 1'b0;
            r_abort    <= 1'b0;
            r_lf_sent  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_vld  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_tx_valid && tx_ready_i)
                r_tx_valid <= 1'b0;

            if (w_err) begin
                // A line ended by an erroneous '\n' needs no skipping afterwards.
                r_err      <= 1'b1;
                r_state    <= S_TMSG;
                r_mem_addr <= w_err_base;
                r_mem_vld  <= 1'b0;
                r_cnt      <= '0;
                r_ok       <= 1'b0;
                r_abort    <= (rx_data_i != CH_LF);
                r_opnd     <= '0;
                r_ndig     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_valid_i) begin
                            r_op    <= w_op;
                            r_state <= S_RDIG;
                        end
                    end
                    S_RDIG: begin
                        if (rx_valid_i) begin
                            if (w_is_dig) begin
                                r_opnd <= {r_opnd[ACC_W-5:0], w_nib};
                                r_ndig <= r_ndig + NW'(1);
                            end else begin
                                r_state <= S_RLF;
                            end
                        end
                    end
                    S_RLF: begin
                        if (rx_valid_i) begin
                            r_acc      <= w_acc_nx;
                            r_state    <= S_TMSG;
                            r_mem_addr <= A_OK;
                            r_mem_vld  <= 1'b0;
                            r_cnt      <= '0;
                            r_ok       <= 1'b1;
                            r_abort    <= 1'b0;
                        end
                    end
                    S_TMSG: begin
                        // mem_data_i is valid one cycle after each new address.
                        if (r_mem_vld && w_slot) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= mem_data_i;
                            r_mem_vld  <= 1'b0;
                            if (r_cnt == CW'(MSG_LEN - 1)) begin
                                r_cnt   <= '0;
                                r_shr   <= r_acc;
                                r_state <= r_ok ? S_TRES : S_TCR;
                            end else begin
                                r_cnt      <= r_cnt + CW'(1);
                                r_mem_addr <= r_mem_addr + MEM_AW'(1);
                            end
                        end else begin
                            r_mem_vld <= 1'b1;
                        end
                    end
                    S_TRES: begin
                        if (w_slot) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= hex_ascii(r_shr[ACC_W-1 -: 4]);
                            r_shr      <= {r_shr[ACC_W-5:0], 4'h0};
                            if (r_cnt == CW'(DIGITS - 1)) begin
                                r_cnt   <= '0;
                                r_state <= S_TCR;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    S_TCR: begin
                        if (w_slot) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= CH_CR;
                            r_lf_sent  <= 1'b0;
                            r_state    <= S_TLF;
                        end
                    end
                    S_TLF: begin
                        // Stay busy until the final '\n' has actually left.
                        if (!r_lf_sent) begin
                            if (w_slot) begin
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= CH_LF;
                                r_lf_sent  <= 1'b1;
                            end
                        end else if (tx_ready_i) begin
                            r_lf_sent <= 1'b0;
                            r_opnd    <= '0;
                            r_ndig    <= '0;
                            r_state   <= r_abort ? S_SKIP : S_IDLE;
                        end
                    end
                    default: begin
                        if (rx_valid_i && rx_data_i == CH_LF) begin
                            r_abort <= 1'b0;
                            r_opnd  <= '0;
                            r_ndig  <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign tx_valid_o  = r_tx_valid;
    assign tx_data_o   = r_tx_data;
    assign mem_addr_o  = r_mem_addr;
    assign acc_o       = r_acc;
    assign busy_o      = (r_state != S_IDLE);
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_is_uart_calc_fsm.sv
// Directed bench for is_uart_calc_fsm with a byte scoreboard on the TX side
// and a synchronous message ROM model.
module tb_is_uart_calc_fsm;

    localparam int DIGITS  = 4;
    localparam int MEM_AW  = 8;
    localparam int MSG_LEN = 4;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              rx_perr_i;
    logic              rx_ferr_i;
    logic              tx_ready_i;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [7:0]        mem_data_i;
    logic [15:0]       acc_o;
    logic              busy_o;
    logic              err_o;
    logic [2:0]        dbg_state_o;

    logic [7:0] rom [0:255];
    logic [7:0] exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int tx_cnt   = 0;
    bit stall_mode = 1'b0;

    is_uart_calc_fsm #(
        .DIGITS(DIGITS), .MEM_AW(MEM_AW), .MSG_LEN(MSG_LEN),
        .OK_BASE(0), .ESYN_BASE(16), .EPAR_BASE(32), .EFRM_BASE(48)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .rx_perr_i(rx_perr_i), .rx_ferr_i(rx_ferr_i),
        .tx_ready_i(tx_ready_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
        .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .acc_o(acc_o), .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // Clock / ROM model
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) mem_data_i <= rom[mem_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rom_put(input int base, input string s);
        for (int i = 0; i < s.len(); i++) rom[base + i] = s[i];
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Driver tasks
    task automatic send_byte(input logic [7:0] b, input logic pe, input logic fe);
        @(posedge clk_i); #1;
        rx_valid_i = 1'b1; rx_data_i = b; rx_perr_i = pe; rx_ferr_i = fe;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0; rx_perr_i = 1'b0; rx_ferr_i = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b0, 1'b0);
            repeat (2) @(posedge clk_i);
        end
    endtask

    task automatic check_latency();
        bit rose = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (tx_valid_o) rose = 1'b1;
        end
        chk("tx_latency", {31'd0, rose}, 32'd1);
    endtask

    task automatic wait_reply(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid_o) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("reply_timeout", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic ok_line(input string body, input string reply, input logic [15:0] acc_exp);
        int e0 = err_cnt;
        push_str(reply);
        send_str(body);
        send_byte(8'h0A, 1'b0, 1'b0);
        check_latency();
        wait_reply(3000);
        chk({"acc ", body}, {16'd0, acc_o}, {16'd0, acc_exp});
        chk("no_err", err_cnt - e0, 32'd0);
        chk("idle_after_ok", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic err_line(input string prefix, input logic [7:0] bad, input logic pe,
                            input logic fe, input string reply, input logic [15:0] acc_exp);
        int e0 = err_cnt;
        push_str(reply);
        send_str(prefix);
        send_byte(bad, pe, fe);
        check_latency();
        wait_reply(3000);
        chk({"err_pulse ", reply.substr(0, 3)}, err_cnt - e0, 32'd1);
        chk("acc_kept", {16'd0, acc_o}, {16'd0, acc_exp});
        chk("skip_state", {29'd0, dbg_state_o}, 32'd7);
        send_str("\r\n");
        repeat (2) @(negedge clk_i);
        chk("skip_to_idle", {31'd0, busy_o}, 32'd0);
    endtask

    // TX ready generator: random back-pressure, or long stalls
    initial begin
        int stall_cnt = 0;
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (stall_mode) begin
                if (stall_cnt >= 50) begin
                    tx_ready_i = 1'b1;
                    stall_cnt  = 0;
                end else begin
                    tx_ready_i = 1'b0;
                    stall_cnt++;
                end
            end else begin
                tx_ready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Scoreboard / monitor
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                prev_stall = 1'b0;
            end else begin
                if (err_o) err_cnt++;
                if (prev_stall)
                    chk("tx_stable", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, prev_data});
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("tx_extra", {24'd0, tx_data_o}, 32'h100);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("tx_byte", {24'd0, tx_data_o}, {24'd0, exp_b});
                    end
                    tx_cnt++;
                end
                prev_stall = tx_valid_o && !tx_ready_i;
                prev_data  = tx_data_o;
            end
        end
    end

    // Directed sequence
    initial begin
        int n;
        int t0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h2E;
        rom_put(0, "OK  ");
        rom_put(16, "ESYN");
        rom_put(32, "EPAR");
        rom_put(48, "EFRM");

        rstn_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        rx_perr_i = 1'b0; rx_ferr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr_o}, 32'd0);
        chk("rst_acc", {16'd0, acc_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;

        ok_line("=1234\r", "OK  1234\r\n", 16'h1234);
        ok_line("+ff\r", "OK  1333\r\n", 16'h1333);
        ok_line("-2000\r", "OK  F333\r\n", 16'hF333);
        err_line("+1234", "5", 1'b0, 1'b0, "ESYN\r\n", 16'hF333);
        ok_line("^1\r", "OK  F332\r\n", 16'hF332);
        err_line("=12", "3", 1'b1, 1'b0, "EPAR\r\n", 16'hF332);
        err_line("=12", "3", 1'b1, 1'b1, "EFRM\r\n", 16'hF332);
        err_line("", "x", 1'b0, 1'b0, "ESYN\r\n", 16'hF332);

        stall_mode = 1'b1;
        ok_line("=A\r", "OK  000A\r\n", 16'h000A);
        stall_mode = 1'b0;

        // Reset while the hex digits are going out
        t0 = tx_cnt;
        push_str("OK  000F\r\n");
        send_str("+5\r");
        send_byte(8'h0A, 1'b0, 1'b0);
        n = 0;
        while (tx_cnt < t0 + 5 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk("tres_timeout", {31'd0, n < 500}, 32'd1);
        #3 rstn_i = 1'b0;
        #1;
        chk("mid_rst_state", {29'd0, dbg_state_o}, 32'd0);
        chk("mid_rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, tx_data_o}, 32'd0);
        chk("mid_rst_mem_addr", {24'd0, mem_addr_o}, 32'd0);
        chk("mid_rst_acc", {16'd0, acc_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_err", {31'd0, err_o}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        ok_line("=1\r", "OK  0001\r\n", 16'h0001);

        repeat (5) @(negedge clk_i);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
